mast_piso_addr_xt: RTL and testbench
====================================

// Module: mast_piso_addr_xt
// PURPOSE
//  Parametrised I2C master address serialiser for 7-bit and 10-bit addressing.
//  Owns an internal bit counter and a byte sequencer, and reports byte/address completion.
//  In 10-bit mode it sends byte 1 (11110,A9,A8,R/W), releases SDA for the ACK, then sends byte 2 (A7..A0).
//  Sits between the master control FSM (start/shift/ack strobes) and the SDA output mux.
// PARAMETERS
//  ADDR_W      10  address width; legal values 7 or 10. At 7, master_ten_bit is ignored (forced 0).
//  MSB_FIRST   1   1: shift out bit 7 first (I2C); 0: LSB first (debug/alt bus)
//  IDLE_LEVEL  1   master_serial_out_addr level when not driving a byte (SDA released)
// PORTS
//  master_scl_sixt         in   1       clock; all state updates on its falling edge
//  master_rst_n            in   1       async reset, active low
//  master_start            in   1       begin an address phase; accepted only in IDLE
//  master_ten_bit          in   1       1: 10-bit address phase; sampled with master_start
//  master_rd_wr            in   1       R/W bit; sampled with master_start
//  master_address          in   ADDR_W  slave address; sampled with master_start
//  master_shift_addr       in   1       advance one bit (one strobe per SCL bit)
//  master_ack_ok           in   1       slave ACKed byte 1; continue to byte 2 (10-bit only)
//  master_abort            in   1       synchronous clear to IDLE
//  master_serial_out_addr  out  1       serial address bit to SDA mux
//  master_addr_busy        out  1       high in any state other than IDLE
//  master_byte_done        out  1       1-cycle pulse after the 8th shift of each byte
//  master_addr_done        out  1       1-cycle pulse after the last bit of the whole address phase
//  master_bit_cnt          out  3       bits already shifted out of the current byte (0..7)
// BEHAVIOUR
//  States: IDLE, BYTE1, WAIT_ACK, BYTE2. All are registered and update on negedge master_scl_sixt.
//  Reset (async, master_rst_n=0):
//   - state=IDLE; shift reg=8'hFF; bit_cnt=0; latched lo-byte=0
//   - busy=0, byte_done=0, addr_done=0, serial_out=IDLE_LEVEL
//  Serial output:
//   - BYTE1/BYTE2: serial_out=shreg[7] if MSB_FIRST, else shreg[0] (combinational from the register)
//   - IDLE/WAIT_ACK: serial_out=IDLE_LEVEL
//  IDLE with master_start=1:
//   - next edge: state=BYTE1, bit_cnt=0
//   - shreg = 7-bit mode: {A6..A0,R/W}; 10-bit mode: {5'b11110,A9,A8,R/W}
//   - latch A7..A0 for byte 2
//   - first bit is valid before the first shift strobe (0-cycle latency after load)
//  BYTE1/BYTE2 with master_shift_addr=1:
//   - MSB_FIRST: shreg<={shreg[6:0],1'b0}; otherwise shreg<={1'b0,shreg[7:1]}
//   - bit_cnt++
//  8th shift (bit_cnt==7 with shift=1):
//   - bit_cnt<=0; byte_done pulses on the next cycle
//   - BYTE1 in 10-bit mode -> WAIT_ACK
//   - BYTE1 in 7-bit mode, or BYTE2 -> IDLE, with addr_done pulsed in the same cycle as byte_done
//  WAIT_ACK:
//   - shift is ignored
//   - master_ack_ok=1 -> shreg=latched A7..A0, bit_cnt=0, state=BYTE2
//   - master NACK handling is done via master_abort
//  Priority: master_abort > master_start/master_ack_ok > master_shift_addr.
//   - abort clears to IDLE: shreg=FF, bit_cnt=0, no byte_done/addr_done pulse
//   - abort and start together in IDLE -> stays IDLE
//  Ignored inputs:
//   - master_start while busy is ignored, and the inputs are not re-sampled
//   - changes to address/rd_wr/ten_bit after start have no effect
//   - shift in IDLE and ack_ok outside WAIT_ACK are ignored
//  10-bit read: byte 1 carries R/W as given. The repeated-start sequence belongs to the master FSM.
//  Reset asserted mid-byte: immediate return to reset values, independent of the clock.
// TESTING
//  T1 7-bit, addr=7'h5A, rw=0, MSB_FIRST=1, 8 shifts:
//     out 1,0,1,1,0,1,0,0; byte_done & addr_done pulse once; busy falls after the 8th shift.
//  T2 10-bit, addr=10'h2C5, rw=1:
//     byte1 0xF5 = 1,1,1,1,0,1,0,1 -> WAIT_ACK (out=1, shifts ignored)
//     -> ack_ok -> byte2 0xC5 = 1,1,0,0,0,1,0,1; addr_done pulses only after byte2.
//  T3 MSB_FIRST=0, 7-bit addr=7'h5A, rw=0: out 0,0,1,0,1,1,0,1 (LSB first).
//  T4 abort after 3 shifts of byte1 (10-bit):
//     IDLE next edge, out=1, bit_cnt=0, no done pulses; a new start then works normally.
//  T5 master_rst_n low mid-BYTE2: busy=0 and out=1 immediately; a new start afterwards sends a fresh byte1.
//  T6 start pulse with a new address while busy, and start+abort together in IDLE:
//     both ignored; the original serial stream is unchanged.

Source files
------------

// File: rtl/mast_piso_addr_xt.sv
// mast_piso_addr_xt: I2C master address serialiser for 7-bit and 10-bit addressing.
module mast_piso_addr_xt #(
    parameter int ADDR_W = 10,
    parameter bit MSB_FIRST = 1'b1,
    parameter bit IDLE_LEVEL = 1'b1
) (
    input  logic              master_scl_sixt,
    input  logic              master_rst_n,
    input  logic              master_start,
    input  logic              master_ten_bit,
    input  logic              master_rd_wr,
    input  logic [ADDR_W-1:0] master_address,
    input  logic              master_shift_addr,
    input  logic              master_ack_ok,
    input  logic              master_abort,
    output logic              master_serial_out_addr,
    output logic              master_addr_busy,
    output logic              master_byte_done,
    output logic              master_addr_done,
    output logic [2:0]        master_bit_cnt
);
    typedef enum logic [1:0] {IDLE, BYTE1, WAIT_ACK, BYTE2} state_t;
    state_t state, state_n;
    logic [7:0] shreg, shreg_n, lo, lo_n;
    logic [2:0] cnt_n;
    logic ten, ten_n, bd_n, ad_n;
    logic [9:0] addr_x;
    logic ten_in;
    // 7-bit builds have no A9/A8, so the address is zero-extended and 10-bit mode disabled
    assign addr_x = 10'(master_address);
    assign ten_in = (ADDR_W == 10) && master_ten_bit;
    assign master_addr_busy = state != IDLE;
    assign master_serial_out_addr = (state == BYTE1 || state == BYTE2) ? (MSB_FIRST ? shreg[7] : shreg[0]) : IDLE_LEVEL;
    always_ff @(negedge master_scl_sixt or negedge master_rst_n) begin
        if (!master_rst_n) begin
            state <= IDLE;
            shreg <= 8'hFF;
            master_bit_cnt <= 3'd0;
            lo <= 8'd0;
            ten <= 1'b0;
            master_byte_done <= 1'b0;
            master_addr_done <= 1'b0;
        end else begin
            state <= state_n;
            shreg <= shreg_n;
            master_bit_cnt <= cnt_n;
            lo <= lo_n;
            ten <= ten_n;
            master_byte_done <= bd_n;
            master_addr_done <= ad_n;
        end
    end
    always_comb begin
        state_n = state;
        shreg_n = shreg;
        cnt_n = master_bit_cnt;
        lo_n = lo;
        ten_n = ten;
        bd_n = 1'b0;
        ad_n = 1'b0;
        if (master_abort) begin
            state_n = IDLE;
            shreg_n = 8'hFF;
            cnt_n = 3'd0;
        end else begin
            case (state)
                IDLE: if (master_start) begin
                    state_n = BYTE1;
                    cnt_n = 3'd0;
                    ten_n = ten_in;
                    lo_n = addr_x[7:0];
                    shreg_n = ten_in ? {5'b11110, addr_x[9:8], master_rd_wr} : {addr_x[6:0], master_rd_wr};
                end
                WAIT_ACK: if (master_ack_ok) begin
                    state_n = BYTE2;
                    shreg_n = lo;
                    cnt_n = 3'd0;
                end
                default: if (master_shift_addr) begin
                    shreg_n = MSB_FIRST ? {shreg[6:0], 1'b0} : {1'b0, shreg[7:1]};
                    cnt_n = master_bit_cnt + 3'd1;
                    if (master_bit_cnt == 3'd7) begin
                        bd_n = 1'b1;
                        state_n = (state == BYTE1 && ten) ? WAIT_ACK : IDLE;
                        ad_n = !(state == BYTE1 && ten);
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mast_piso_addr_xt.sv
// tb_mast_piso_addr_xt: directed checks of the address serialiser, MSB-first 10-bit build plus an LSB-first 7-bit build.
module tb_mast_piso_addr_xt;
    logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, ten = 1'b0, rw = 1'b0;
    logic shift = 1'b0, ack = 1'b0, abort = 1'b0;
    logic [9:0] addr = 10'd0;
    logic out, busy, bd, ad, out_l, busy_l, bd_l, ad_l;
    logic [2:0] cnt, cnt_l;
    int compared = 0, mismatched = 0;

    mast_piso_addr_xt dut (
        .master_scl_sixt(clk), .master_rst_n(rst_n), .master_start(start), .master_ten_bit(ten),
        .master_rd_wr(rw), .master_address(addr), .master_shift_addr(shift), .master_ack_ok(ack),
        .master_abort(abort), .master_serial_out_addr(out), .master_addr_busy(busy),
        .master_byte_done(bd), .master_addr_done(ad), .master_bit_cnt(cnt)
    );

    mast_piso_addr_xt #(.ADDR_W(7), .MSB_FIRST(1'b0)) dut_l (
        .master_scl_sixt(clk), .master_rst_n(rst_n), .master_start(start), .master_ten_bit(ten),
        .master_rd_wr(rw), .master_address(addr[6:0]), .master_shift_addr(shift), .master_ack_ok(ack),
        .master_abort(abort), .master_serial_out_addr(out_l), .master_addr_busy(busy_l),
        .master_byte_done(bd_l), .master_addr_done(ad_l), .master_bit_cnt(cnt_l)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic start_addr(input logic [9:0] a, input logic r, input logic t);
        addr = a;
        rw = r;
        ten = t;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic shift_byte(input string tag, input logic [7:0] e, input logic [7:0] el, input bit chk_l);
        for (int i = 0; i < 8; i++) begin
            chk({tag, "_out"}, out, e[7-i]);
            chk({tag, "_cnt"}, cnt, i);
            chk({tag, "_bd"}, bd, 0);
            if (chk_l) chk({tag, "_out_l"}, out_l, el[i]);
            shift = 1'b1;
            tick();
        end
        shift = 1'b0;
    endtask

    initial begin
        tick();
        chk("rst_busy", busy, 0);
        chk("rst_out", out, 1);
        chk("rst_cnt", cnt, 0);
        chk("rst_bd", bd, 0);
        chk("rst_ad", ad, 0);
        chk("rst_out_l", out_l, 1);
        rst_n = 1'b1;
        tick();
        shift = 1'b1;
        tick();
        shift = 1'b0;
        chk("idle_shift_busy", busy, 0);
        // T1 and T3 together: 0x5A rw=0 -> 0xB4
        start_addr(10'h05A, 1'b0, 1'b0);
        chk("t1_busy", busy, 1);
        shift_byte("t1", 8'hB4, 8'hB4, 1'b1);
        chk("t1_bd", bd, 1);
        chk("t1_ad", ad, 1);
        chk("t1_busy_end", busy, 0);
        chk("t3_ad", ad_l, 1);
        tick();
        chk("t1_bd_pulse", bd, 0);
        chk("t1_ad_pulse", ad, 0);
        // T2 with T6: restart with a new address mid-byte must be ignored
        start_addr(10'h2C5, 1'b1, 1'b1);
        for (int i = 0; i < 8; i++) begin
            chk("t2_b1_out", out, (8'hF5 >> (7 - i)) & 8'h1);
            chk("t2_l_out", out_l, (8'h8B >> i) & 8'h1);
            shift = 1'b1;
            if (i == 3) begin
                start = 1'b1;
                addr = 10'h3FF;
                rw = 1'b0;
            end
            tick();
            start = 1'b0;
        end
        shift = 1'b0;
        chk("t2_b1_bd", bd, 1);
        chk("t2_b1_ad", ad, 0);
        chk("t2_l_ad", ad_l, 1);
        chk("t2_wait_out", out, 1);
        chk("t2_wait_busy", busy, 1);
        shift = 1'b1;
        tick();
        tick();
        shift = 1'b0;
        chk("t2_wait_cnt", cnt, 0);
        chk("t2_wait_out2", out, 1);
        chk("t2_wait_busy2", busy, 1);
        ack = 1'b1;
        tick();
        ack = 1'b0;
        chk("t2_l_idle", busy_l, 0);
        shift_byte("t2_b2", 8'hC5, 8'h00, 1'b0);
        chk("t2_b2_bd", bd, 1);
        chk("t2_b2_ad", ad, 1);
        chk("t2_b2_busy", busy, 0);
        // T6: start and abort together in IDLE
        addr = 10'h2C5;
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        chk("t6_busy", busy, 0);
        chk("t6_out", out, 1);
        // T4: abort after three shifts of byte 1
        start_addr(10'h2C5, 1'b1, 1'b1);
        shift = 1'b1;
        tick();
        tick();
        tick();
        shift = 1'b0;
        chk("t4_cnt3", cnt, 3);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("t4_busy", busy, 0);
        chk("t4_out", out, 1);
        chk("t4_cnt", cnt, 0);
        chk("t4_bd", bd, 0);
        chk("t4_ad", ad, 0);
        tick();
        chk("t4_bd2", bd, 0);
        start_addr(10'h05A, 1'b1, 1'b0);
        shift_byte("t4_new", 8'hB5, 8'hB5, 1'b1);
        chk("t4_new_ad", ad, 1);
        // T5: reset mid byte 2, then a fresh byte 1
        start_addr(10'h2C5, 1'b0, 1'b1);
        shift_byte("t5_b1", 8'hF4, 8'h00, 1'b0);
        ack = 1'b1;
        tick();
        ack = 1'b0;
        shift = 1'b1;
        tick();
        tick();
        shift = 1'b0;
        chk("t5_b2_busy", busy, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("t5_rst_busy", busy, 0);
        chk("t5_rst_out", out, 1);
        chk("t5_rst_cnt", cnt, 0);
        tick();
        rst_n = 1'b1;
        start_addr(10'h0C5, 1'b0, 1'b1);
        shift_byte("t5_new", 8'hF0, 8'h00, 1'b0);
        chk("t5_new_bd", bd, 1);
        chk("t5_new_ad", ad, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
